// File: rtl/calc_result_display.sv
// Result stage after the 3-bit subtractor: captures {sign,value}, converts it to
// sign-magnitude and drives a 2-digit multiplexed 7-segment display.
module calc_result_display #(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] res_in,
   input  logic       res_valid,
   input  logic       clear,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       neg_out,
   output logic [2:0] mag_out,
   output logic       shown
);

   localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0]    AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

   typedef enum logic {BLANK, HOLD} state_t;

   state_t        state_q, state_d;
   logic          neg_q, neg_d;
   logic [2:0]    mag_q, mag_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          cap_neg;
   logic [6:0]    seg_hi;
   logic [1:0]    an_hi;

   function automatic logic [6:0] glyph(input logic [2:0] d);
      case (d)
         3'd0: glyph = 7'h3F;
         3'd1: glyph = 7'h06;
         3'd2: glyph = 7'h5B;
         3'd3: glyph = 7'h4F;
         3'd4: glyph = 7'h66;
         3'd5: glyph = 7'h6D;
         3'd6: glyph = 7'h7D;
         3'd7: glyph = 7'h07;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      seg_hi  = 7'h00;
      an_hi   = 2'b00;

      // Scan runs free; only reset disturbs it.
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         sel_d = ~sel_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // -0 (sign set, value zero) normalises to +0.
      cap_neg = res_in[3] & (res_in[2:0] != 3'd0);
      if (clear) begin
         if (state_q == HOLD) state_d = BLANK;
      end else if (res_valid) begin
         state_d = HOLD;
         neg_d   = cap_neg;
         mag_d   = cap_neg ? (~res_in[2:0] + 3'd1) : res_in[2:0];
      end

      if (state_q == HOLD) begin
         if (!sel_q) begin
            an_hi  = 2'b01;
            seg_hi = glyph(mag_q);
         end else begin
            an_hi  = 2'b10;
            seg_hi = neg_q ? 7'h40 : 7'h00;
         end
      end
      seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      an_d  = SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BLANK;
         neg_q   <= 1'b0;
         mag_q   <= 3'd0;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         seg_q   <= SEG_OFF;
         an_q    <= AN_OFF;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg     = seg_q;
   assign an      = an_q;
   assign neg_out = neg_q;
   assign mag_out = mag_q;
   assign shown   = (state_q == HOLD);

endmodule
